// File: rtl/bcd_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scan_if
// Brief    : Source words in, multiplexed 7-segment drive out.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_display_scan_if;
    logic [23:0] time_in;
    logic [23:0] date_in;
    logic [2:0]  weekday_in;
    logic        ampm;
    logic [1:0]  disp_sel;
    logic [2:0]  blink_mask;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output time_in, date_in, weekday_in, ampm, disp_sel, blink_mask,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  time_in, date_in, weekday_in, ampm, disp_sel, blink_mask,
        output an, seg, dp, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/bcd_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_scan
// Brief    : Six-digit common-anode scan driver with per-frame snapshot,
//            BCD decode and pair blinking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    bcd_display_scan_if.slave bus
);
    localparam int c_CNT_W = $clog2(SCAN_DIV);
    localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_PRE  = c_CNT_W'(SCAN_DIV - 2);
    localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]         c_IDX_LAST = 3'd5;

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [c_FRM_W-1:0] r_frm_cnt;
    logic               r_blink_phase;
    logic [23:0]        r_snap_time;
    logic [23:0]        r_snap_date;
    logic [2:0]         r_snap_wd;
    logic               r_snap_ampm;
    logic [1:0]         r_snap_sel;
    logic [2:0]         r_snap_blink;
    logic [5:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_frame_tick;

    logic               w_cnt_end;
    logic               w_frame_end;
    logic               w_pre_end;
    logic [23:0]        w_word;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic               w_pair_blink;
    logic               w_dp_n;
    logic [6:0]         w_seg_n;
    logic [5:0]         w_an;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign w_cnt_end   = (r_cnt == c_CNT_LAST);
    assign w_frame_end = w_cnt_end && (r_idx == c_IDX_LAST);
    // Looking one cycle ahead lets frame_tick be a register yet coincide with frame end
    assign w_pre_end   = (r_cnt == c_CNT_PRE) && (r_idx == c_IDX_LAST);

    always_comb begin
        w_word       = 24'h0;
        w_blank      = 1'b0;
        w_nib        = 4'h0;
        w_pair_blink = 1'b0;
        w_dp_n       = 1'b1;
        case (r_snap_sel)
            2'b00:   w_word = r_snap_time;
            2'b01:   w_word = r_snap_date;
            2'b10: begin
                w_word  = {20'h0, {1'b0, r_snap_wd} + 4'd1};
                w_blank = (r_idx != 3'd0);
            end
            default: w_blank = 1'b1;
        endcase

        case (r_idx)
            3'd0:    w_nib = w_word[3:0];
            3'd1:    w_nib = w_word[7:4];
            3'd2:    w_nib = w_word[11:8];
            3'd3:    w_nib = w_word[15:12];
            3'd4:    w_nib = w_word[19:16];
            default: w_nib = w_word[23:20];
        endcase

        case (r_idx)
            3'd0, 3'd1: w_pair_blink = r_blink_phase & r_snap_blink[0];
            3'd2, 3'd3: w_pair_blink = r_blink_phase & r_snap_blink[1];
            default:    w_pair_blink = r_blink_phase & r_snap_blink[2];
        endcase

        if (!r_snap_sel[1] && ((r_idx == 3'd2) || (r_idx == 3'd4)))
            w_dp_n = 1'b0;
        if ((r_snap_sel == 2'b00) && (r_idx == 3'd0) && r_snap_ampm)
            w_dp_n = 1'b0;
        if (w_pair_blink)
            w_dp_n = 1'b1;
    end

    assign w_seg_n = (w_blank || w_pair_blink) ? 7'h7f : seg_decode(w_nib);
    assign w_an    = (r_snap_sel == 2'b11) ? 6'h3f : ~(6'd1 << r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_frm_cnt     <= '0;
            r_blink_phase <= 1'b0;
            r_snap_time   <= 24'h0;
            r_snap_date   <= 24'h0;
            r_snap_wd     <= 3'd0;
            r_snap_ampm   <= 1'b0;
            r_snap_sel    <= 2'b00;
            r_snap_blink  <= 3'b000;
            r_an          <= 6'h3f;
            r_seg         <= 7'h7f;
            r_dp          <= 1'b1;
            r_frame_tick  <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_end ? '0 : r_cnt + c_CNT_W'(1);
            r_frame_tick <= w_pre_end;
            if (w_cnt_end)
                r_idx <= (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
            if (w_frame_end) begin
                r_snap_time  <= bus.time_in;
                r_snap_date  <= bus.date_in;
                r_snap_wd    <= bus.weekday_in;
                r_snap_ampm  <= bus.ampm;
                r_snap_sel   <= bus.disp_sel;
                r_snap_blink <= bus.blink_mask;
                if (r_frm_cnt == c_FRM_LAST) begin
                    r_frm_cnt     <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frm_cnt <= r_frm_cnt + c_FRM_W'(1);
                end
            end
            r_an  <= w_an;
            r_seg <= w_seg_n;
            r_dp  <= w_dp_n;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;
endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_scan
// Brief    : Frame-by-frame checks of the scan driver against a table of
//            hand-decoded display frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scan;
    localparam int c_SCAN_DIV     = 4;
    localparam int c_BLINK_FRAMES = 2;
    localparam int c_FRAME        = 6 * c_SCAN_DIV;

    localparam logic [6:0] c_S0 = 7'b1000000;
    localparam logic [6:0] c_S1 = 7'b1111001;
    localparam logic [6:0] c_S2 = 7'b0100100;
    localparam logic [6:0] c_S3 = 7'b0110000;
    localparam logic [6:0] c_S4 = 7'b0011001;
    localparam logic [6:0] c_S5 = 7'b0010010;
    localparam logic [6:0] c_S6 = 7'b0000010;
    localparam logic [6:0] c_S7 = 7'b1111000;
    localparam logic [6:0] c_S8 = 7'b0000000;
    localparam logic [6:0] c_S9 = 7'b0010000;
    localparam logic [6:0] c_SD = 7'b0111111;
    localparam logic [6:0] c_SB = 7'b1111111;

    typedef struct packed {
        logic [1:0]      sel;
        logic [23:0]     tim;
        logic [23:0]     dat;
        logic [2:0]      wd;
        logic            amp;
        logic [2:0]      bm;
        logic [5:0][6:0] segs;    // [5] is the leftmost digit
        logic [5:0]      dpn;
        logic            an_off;
    } vec_t;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    localparam exp_t c_OFF = {6'h3f, 7'h7f, 1'b1};

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    exp_t sb_q[$];
    vec_t tbl[14];
    int   sched[17];

    bcd_display_scan_if bus();

    bcd_display_scan #(
        .SCAN_DIV     (c_SCAN_DIV),
        .BLINK_FRAMES (c_BLINK_FRAMES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary by 200000ns, want finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [1:0] sel, input logic [23:0] tim, dat,
                                input logic [2:0] wd, input logic amp, input logic [2:0] bm,
                                input logic [5:0][6:0] segs, input logic [5:0] dpn,
                                input logic an_off);
        vec_t v;
        v.sel = sel; v.tim = tim; v.dat = dat; v.wd = wd; v.amp = amp; v.bm = bm;
        v.segs = segs; v.dpn = dpn; v.an_off = an_off;
        return v;
    endfunction

    task automatic set_inputs(input vec_t v);
        bus.disp_sel   = v.sel;
        bus.time_in    = v.tim;
        bus.date_in    = v.dat;
        bus.weekday_in = v.wd;
        bus.ampm       = v.amp;
        bus.blink_mask = v.bm;
    endtask

    task automatic push_frame(input vec_t v);
        exp_t e;
        for (int d = 0; d < 6; d++) begin
            e.an  = v.an_off ? 6'h3f : ~(6'd1 << d);
            e.seg = v.segs[d];
            e.dp  = v.dpn[d];
            sb_q.push_back(e);
        end
    endtask

    task automatic drive(input vec_t v);
        set_inputs(v);
        push_frame(v);
    endtask

    task automatic check_cycle(input exp_t e, input logic tick_exp, input string tag, input int k);
        n_vec++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {e.an, e.seg, e.dp, tick_exp}) begin
            n_miss++;
            $display("FAIL %s slot %0d: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
                     tag, k, bus.an, bus.seg, bus.dp, bus.frame_tick, e.an, e.seg, e.dp, tick_exp);
        end
    endtask

    // Starts on the cycle right after a frame end; drives the next frame's inputs at slot dk
    task automatic check_frame(input vec_t nxt, input int dk, input string tag);
        exp_t cur;
        cur = c_OFF;
        if (sb_q.size() < 6) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s scoreboard: got %0d entries, want 6", tag, sb_q.size());
        end
        for (int k = 0; k < c_FRAME; k++) begin
            @(negedge clk);
            if ((k % c_SCAN_DIV) == 0 && sb_q.size() > 0)
                cur = sb_q.pop_front();
            check_cycle(cur, (k == c_FRAME - 2), tag, k);
            if (k == dk)
                drive(nxt);
        end
    endtask

    initial begin
        exp_t cur;
        n_vec  = 0;
        n_miss = 0;
        cur    = c_OFF;

        tbl[0]  = mk(2'b00, 24'h000000, 24'h000000, 3'd0, 1'b0, 3'b000,
                     {c_S0, c_S0, c_S0, c_S0, c_S0, c_S0}, 6'b101011, 1'b0);
        tbl[1]  = mk(2'b00, 24'h123456, 24'h000000, 3'd0, 1'b0, 3'b000,
                     {c_S1, c_S2, c_S3, c_S4, c_S5, c_S6}, 6'b101011, 1'b0);
        tbl[2]  = mk(2'b00, 24'h235959, 24'h000000, 3'd0, 1'b0, 3'b000,
                     {c_S2, c_S3, c_S5, c_S9, c_S5, c_S9}, 6'b101011, 1'b0);
        tbl[3]  = mk(2'b00, 24'h000000, 24'h000000, 3'd0, 1'b0, 3'b000,
                     {c_S0, c_S0, c_S0, c_S0, c_S0, c_S0}, 6'b101011, 1'b0);
        tbl[4]  = mk(2'b10, 24'h987654, 24'h121212, 3'd3, 1'b0, 3'b000,
                     {c_SB, c_SB, c_SB, c_SB, c_SB, c_S4}, 6'b111111, 1'b0);
        tbl[5]  = mk(2'b11, 24'h123456, 24'h121212, 3'd2, 1'b1, 3'b000,
                     {c_SB, c_SB, c_SB, c_SB, c_SB, c_SB}, 6'b111111, 1'b1);
        tbl[6]  = mk(2'b01, 24'h111111, 24'h1C0725, 3'd0, 1'b1, 3'b000,
                     {c_S1, c_SD, c_S0, c_S7, c_S2, c_S5}, 6'b101011, 1'b0);
        tbl[7]  = mk(2'b00, 24'h114508, 24'h000000, 3'd0, 1'b1, 3'b000,
                     {c_S1, c_S1, c_S4, c_S5, c_S0, c_S8}, 6'b101010, 1'b0);
        tbl[8]  = mk(2'b10, 24'h220000, 24'h000000, 3'd7, 1'b1, 3'b000,
                     {c_SB, c_SB, c_SB, c_SB, c_SB, c_S8}, 6'b111111, 1'b0);
        tbl[9]  = mk(2'b00, 24'h9F8A76, 24'h000000, 3'd0, 1'b0, 3'b000,
                     {c_S9, c_SD, c_S8, c_SD, c_S7, c_S6}, 6'b101011, 1'b0);
        tbl[10] = mk(2'b00, 24'h123456, 24'h000000, 3'd0, 1'b0, 3'b100,
                     {c_S1, c_S2, c_S3, c_S4, c_S5, c_S6}, 6'b101011, 1'b0);
        tbl[11] = mk(2'b00, 24'h123456, 24'h000000, 3'd0, 1'b0, 3'b100,
                     {c_SB, c_SB, c_S3, c_S4, c_S5, c_S6}, 6'b111011, 1'b0);
        tbl[12] = mk(2'b00, 24'h123456, 24'h000000, 3'd0, 1'b1, 3'b001,
                     {c_S1, c_S2, c_S3, c_S4, c_S5, c_S6}, 6'b101010, 1'b0);
        tbl[13] = mk(2'b00, 24'h123456, 24'h000000, 3'd0, 1'b1, 3'b001,
                     {c_S1, c_S2, c_S3, c_S4, c_SB, c_SB}, 6'b101011, 1'b0);

        // Frame n+2 shows tbl[sched[n]]; blink phase flips every second frame from frame 3
        sched = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 11, 10, 10, 11, 13, 12, 12};

        rst = 1'b1;
        set_inputs(tbl[1]);
        repeat (3) @(negedge clk);
        check_cycle(c_OFF, 1'b0, "reset", 0);
        rst = 1'b0;
        push_frame(tbl[0]);

        for (int f = 0; f < 17; f++)
            check_frame(tbl[sched[f]], (f == 2) ? 11 : 0, $sformatf("frame %0d", f + 1));

        // Frame 18: reset pulse while the scan sits on digit 3
        for (int k = 0; k <= 3 * c_SCAN_DIV; k++) begin
            @(negedge clk);
            if ((k % c_SCAN_DIV) == 0 && sb_q.size() > 0)
                cur = sb_q.pop_front();
            check_cycle(cur, 1'b0, "frame 18", k);
        end
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check_cycle(c_OFF, 1'b0, "mid-scan reset", 0);
        rst = 1'b0;
        push_frame(tbl[0]);
        check_frame(tbl[1], 0, "post-reset 1");
        check_frame(tbl[1], -1, "post-reset 2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
